deconv_kernel_sram_sequencer: RTL

- Controller that owns the magnitude and phase deconvolution-kernel SRAM interfaces.
- Capture: steers the kernel estimator's output word stream into the correct SRAM.
- Dump: sequences debug readout of both SRAMs onto one valid/ready word stream (magnitude first, then phase) for the debug serializer.
- Owns the interfaces' pointer rewind (sram_rst_n), write enables, debug/ren, and read-trigger pulses.

---
 rtl/deconv_kernel_sram_sequencer_pkg.sv | 29 ++
 rtl/deconv_kernel_sram_sequencer_readout_port.sv | 70 +++++++
 rtl/deconv_kernel_sram_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/deconv_kernel_sram_sequencer_pkg.sv
// rtl/deconv_kernel_sram_sequencer_pkg.sv - shared types and defaults for the deconvolution-kernel SRAM sequencer
package deconv_kernel_sram_sequencer_pkg;

    // Defaults match the 4k-SRAM kernel estimator build
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DEPTH      = 2048;
    localparam int DEF_CNT_WIDTH  = 12;

    // dout_sel / internal SRAM select encoding
    localparam logic DOUT_SEL_MAG   = 1'b0;
    localparam logic DOUT_SEL_PHASE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_CAPTURED = 3'd3,
        ST_PRIME    = 3'd4,
        ST_PRESENT  = 3'd5,
        ST_WAIT     = 3'd6
    } seq_state_t;

    // True while an SRAM is held in debug/read mode
    function automatic logic is_reading(seq_state_t s);
        return (s == ST_PRIME) || (s == ST_PRESENT) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/deconv_kernel_sram_sequencer_readout_port.sv
// rtl/deconv_kernel_sram_sequencer_readout_port.sv - shared read engine: rd_cnt, word presentation and read-pointer pulses
module deconv_kernel_sram_readout_port
    import deconv_kernel_sram_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  seq_state_t            state_i,
    input  logic                  sel_i,
    input  logic [CNT_WIDTH-1:0]  mag_cnt_i,
    input  logic [CNT_WIDTH-1:0]  phase_cnt_i,
    input  logic [DATA_WIDTH-1:0] mag_rdata_i,
    input  logic [DATA_WIDTH-1:0] phase_rdata_i,
    input  logic                  dout_ready_i,
    output logic                  dout_valid_o,
    output logic [DATA_WIDTH-1:0] dout_data_o,
    output logic                  dout_last_o,
    output logic                  xfer_o,
    output logic                  sram_end_o,
    output logic                  mag_read_trig_o,
    output logic                  phase_read_trig_o
);

    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic                 at_end;
    logic                 mag_trig_q, phase_trig_q;

    // Present the selected SRAM word and detect the final word of that SRAM
    always_comb begin
        cur_cnt      = (sel_i == DOUT_SEL_PHASE) ? phase_cnt_i : mag_cnt_i;
        at_end       = (rd_cnt_q == cur_cnt - CNT_WIDTH'(1));
        dout_valid_o = (state_i == ST_PRESENT);
        dout_data_o  = '0;
        if (dout_valid_o) begin
            dout_data_o = (sel_i == DOUT_SEL_PHASE) ? phase_rdata_i : mag_rdata_i;
        end
        // Phase is always read last; mag is last only when phase holds nothing
        dout_last_o  = dout_valid_o && at_end &&
                       ((sel_i == DOUT_SEL_PHASE) || (phase_cnt_i == '0));
        xfer_o       = dout_valid_o && dout_ready_i;
        sram_end_o   = xfer_o && at_end;
        rd_cnt_d     = rd_cnt_q;
        // Any state outside PRESENT/WAIT restarts the word count, so PRIME always begins at 0
        if ((state_i != ST_PRESENT) && (state_i != ST_WAIT)) begin
            rd_cnt_d = '0;
        end else if (xfer_o) begin
            rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Word counter and one-cycle read-pointer advance after each accepted word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q     <= '0;
            mag_trig_q   <= 1'b0;
            phase_trig_q <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            mag_trig_q   <= xfer_o && (sel_i == DOUT_SEL_MAG);
            phase_trig_q <= xfer_o && (sel_i == DOUT_SEL_PHASE);
        end
    end

    assign mag_read_trig_o   = mag_trig_q;
    assign phase_read_trig_o = phase_trig_q;

endmodule

// File: rtl/deconv_kernel_sram_sequencer.sv
// rtl/deconv_kernel_sram_sequencer.sv - capture and debug-dump controller for the magnitude/phase kernel SRAMs
module deconv_kernel_sram_sequencer
    import deconv_kernel_sram_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  est_valid,
    input  logic                  est_is_phase,
    input  logic [DATA_WIDTH-1:0] est_data,
    input  logic                  est_done,
    input  logic                  dump_req,
    output logic                  sram_rst_n,
    output logic                  mag_wen,
    output logic                  phase_wen,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  mag_debug,
    output logic                  phase_debug,
    output logic                  mag_read_trig,
    output logic                  phase_read_trig,
    input  logic [DATA_WIDTH-1:0] mag_rdata,
    input  logic [DATA_WIDTH-1:0] phase_rdata,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_sel,
    output logic                  dout_last,
    output logic                  busy,
    output logic                  captured,
    output logic                  overflow
);

    if (((1 << CNT_WIDTH) <= DEPTH) || ((1 << ADDR_WIDTH) < DEPTH)) begin : g_bad_params
        $error("deconv_kernel_sram_sequencer: counter or address too narrow for DEPTH");
    end

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    seq_state_t            state_q, state_d;
    logic                  sel_q, sel_d;
    logic [CNT_WIDTH-1:0]  mag_cnt_q, phase_cnt_q;
    logic                  overflow_q;
    logic                  mag_wen_q, phase_wen_q;
    logic [DATA_WIDTH-1:0] sram_wdata_q;
    logic                  sram_rst_n_q;
    logic                  mag_debug_q, phase_debug_q;
    logic                  busy_q, captured_q;
    logic                  xfer, sram_end;

    deconv_kernel_sram_readout_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_readout (
        .clk               (clk),
        .rst_n             (rst_n),
        .state_i           (state_q),
        .sel_i             (sel_q),
        .mag_cnt_i         (mag_cnt_q),
        .phase_cnt_i       (phase_cnt_q),
        .mag_rdata_i       (mag_rdata),
        .phase_rdata_i     (phase_rdata),
        .dout_ready_i      (dout_ready),
        .dout_valid_o      (dout_valid),
        .dout_data_o       (dout_data),
        .dout_last_o       (dout_last),
        .xfer_o            (xfer),
        .sram_end_o        (sram_end),
        .mag_read_trig_o   (mag_read_trig),
        .phase_read_trig_o (phase_read_trig)
    );

    // Next state and SRAM select
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (est_done) state_d = ST_CAPTURED;
            end
            ST_CAPTURED: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end else if (dump_req) begin
                    // Magnitude is dumped first; an empty SRAM is skipped entirely
                    if (mag_cnt_q != '0) begin
                        sel_d   = DOUT_SEL_MAG;
                        state_d = ST_PRIME;
                    end else if (phase_cnt_q != '0) begin
                        sel_d   = DOUT_SEL_PHASE;
                        state_d = ST_PRIME;
                    end
                end
            end
            ST_PRIME: begin
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (sram_end) begin
                    if ((sel_q == DOUT_SEL_MAG) && (phase_cnt_q != '0)) begin
                        sel_d   = DOUT_SEL_PHASE;
                        state_d = ST_PRIME;
                    end else begin
                        state_d = ST_CAPTURED;
                    end
                end else if (xfer) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_PRESENT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, capture counters and registered SRAM/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= DOUT_SEL_MAG;
            mag_cnt_q     <= '0;
            phase_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            mag_wen_q     <= 1'b0;
            phase_wen_q   <= 1'b0;
            sram_wdata_q  <= '0;
            sram_rst_n_q  <= 1'b0;
            mag_debug_q   <= 1'b0;
            phase_debug_q <= 1'b0;
            busy_q        <= 1'b0;
            captured_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            sram_rst_n_q  <= (state_d != ST_CLEAR);
            mag_debug_q   <= is_reading(state_d) && (sel_d == DOUT_SEL_MAG);
            phase_debug_q <= is_reading(state_d) && (sel_d == DOUT_SEL_PHASE);
            busy_q        <= (state_d != ST_IDLE) && (state_d != ST_CAPTURED);
            captured_q    <= (state_d == ST_CAPTURED);
            mag_wen_q     <= 1'b0;
            phase_wen_q   <= 1'b0;
            if (state_d == ST_CLEAR) begin
                mag_cnt_q   <= '0;
                phase_cnt_q <= '0;
                overflow_q  <= 1'b0;
            end
            // A full SRAM drops the word instead of wrapping its pointer
            if ((state_q == ST_CAPTURE) && est_valid) begin
                sram_wdata_q <= est_data;
                if (est_is_phase) begin
                    if (phase_cnt_q == DEPTH_C) begin
                        overflow_q <= 1'b1;
                    end else begin
                        phase_wen_q <= 1'b1;
                        phase_cnt_q <= phase_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    if (mag_cnt_q == DEPTH_C) begin
                        overflow_q <= 1'b1;
                    end else begin
                        mag_wen_q <= 1'b1;
                        mag_cnt_q <= mag_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign sram_rst_n  = sram_rst_n_q;
    assign mag_wen     = mag_wen_q;
    assign phase_wen   = phase_wen_q;
    assign sram_wdata  = sram_wdata_q;
    assign mag_debug   = mag_debug_q;
    assign phase_debug = phase_debug_q;
    assign dout_sel    = sel_q;
    assign busy        = busy_q;
    assign captured    = captured_q;
    assign overflow    = overflow_q;

endmodule
